proc_top_layer: RTL and testbench
=================================

// Module: proc_top_layer
// PURPOSE
//  Top level of a 16-bit accumulator processor: 512x16 instruction RAM (IRAM), 512x16 data RAM (DRAM), control FSM, ALU.
//  While not running, a testbench/host loads both RAMs and reads them back through the external port.
//  A start pulse then runs the program from IRAM address 1 until HALT.
// PARAMETERS
//  AW     9    RAM address width (512 words each)
//  DW     16   data/instruction width
//  PC0    1    program start address
// PORTS
//  clk                 in   1   system clock, all state on rising edge
//  rst                 in   1   asynchronous, active-high reset
//  start               in   1   level; sampled in IDLE/HALT to launch program
//  mem_write_ins       in   1   external IRAM write enable
//  mem_write_data_ext  in   1   external DRAM write enable
//  read_en_ext         in   2   [0]=IRAM readback, [1]=DRAM readback
//  addr_ext            in   16  external address; bits [8:0] used, [15:9] ignored
//  iram_in_ext         in   16  external IRAM write data
//  data_in_ext         in   16  external DRAM write data
//  iram_in             out  16  IRAM read data (instruction to core / readback)
//  data_out            out  16  DRAM read data register (readback / display)
//  dram_in             out  16  DRAM write-data bus
//  addr_out            out  16  DRAM address bus, zero-extended
//  addr_ins            out  9   IRAM address bus (PC when running)
//  state               out  6   FSM state code
// BEHAVIOUR
//  Reset: state=IDLE, PC=1, ACC=0, Z=1, all outputs 0; RAM contents not cleared. Reset mid-run aborts immediately.
//  Instruction format: [15:12] opcode, [8:0] operand, [11:9] ignored.
//  Opcodes: 0 NOP; 1 LOAD ACC=M[a]; 2 STORE M[a]=ACC; 3 ADD; 4 SUB; 5 MUL (low 16b); 6 JMP PC=a; 7 JZ (if Z) PC=a;
//           8 LDI ACC=zero-ext a; F HALT; others execute as NOP.
//  Arithmetic: 16-bit modulo, no carry/overflow flags; Z updated on every ACC write (Z = ACC==0).
//  States: IDLE=6'h00, FETCH=6'h01, FWAIT=6'h02, DECODE=6'h03, MEMRD=6'h04, EXEC=6'h05, HALT=6'h3F.
//  IDLE/HALT: start=1 -> FETCH, PC=1, ACC=0, Z=1. Otherwise stay.
//  FETCH: addr_ins=PC, sync IRAM read issued. FWAIT: iram_in/IR captured. DECODE: PC<=PC+1 (9-bit wrap 511->0).
//  DECODE: LOAD/ADD/SUB/MUL -> drive addr_out=a, go MEMRD; STORE -> write DRAM[a]=ACC (dram_in=ACC), go FETCH;
//          JMP/JZ-taken -> PC=a, go FETCH; LDI/NOP -> update, go FETCH; HALT -> HALT.
//  MEMRD: DRAM q valid, registered into data_out. EXEC: ACC updated from data_out, go FETCH.
//  Cycles/instr: STORE/JMP/JZ/LDI/NOP = 3, LOAD/ALU = 5.
//  External access honoured only in IDLE/HALT; ignored while running.
//  Ext write: rising edge with mem_write_ins=1 writes IRAM[addr_ext[8:0]]; mem_write_data_ext=1 writes DRAM;
//    both set -> both written. dram_in mirrors data_in_ext during ext DRAM write.
//  Ext read: 1-cycle latency; read_en_ext[0] -> iram_in=IRAM[addr_ext] next cycle, [1] -> data_out=DRAM[addr_ext].
//    read_en_ext=00 -> outputs hold. Write and read same address same cycle -> old data returned (read-first).
//  start held high through HALT restarts program; start ignored while running.
//  addr_ins/addr_out follow addr_ext when idle, FSM addresses when running.
// TESTING
//  Load DRAM[1]=5, [2]=7; IRAM 1:0x1001 2:0x3002 3:0x2003 4:0xF000; start -> DRAM[3]=12, state=6'h3F.
//  Same with op 0x5002 (MUL) -> 35; DRAM[1]=300,[2]=300 -> 24464; op 0x4002 (SUB) 5-7 -> 0xFFFE.
//  LDI 0 (0x8000), JZ 5 (0x7005), LDI 1, HALT at 5 -> ACC=0 (branch taken), PC passes 5.
//  Readback: write DRAM[9]=0xBEEF, read_en_ext=10 -> data_out=0xBEEF one cycle later; IRAM via 01.
//  While running assert mem_write_data_ext to DRAM[3]=0xFFFF -> ignored, DRAM[3]=12 after HALT.
//  Assert rst in MEMRD -> state=0, ACC=0, PC=1 immediately; RAM contents preserved; restart reproduces result.

Source files
------------

// File: rtl/proc_top_layer.sv
// 16-bit accumulator processor: 512x16 instruction RAM, 512x16 data RAM, control FSM and ALU.
// The host loads and reads back both RAMs while the core sits in IDLE or HALT.
module proc_top_layer #(
   parameter int AW  = 9,
   parameter int DW  = 16,
   parameter int PC0 = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mem_write_ins,
   input  logic          mem_write_data_ext,
   input  logic [1:0]    read_en_ext,
   input  logic [15:0]   addr_ext,
   input  logic [DW-1:0] iram_in_ext,
   input  logic [DW-1:0] data_in_ext,
   output logic [DW-1:0] iram_in,
   output logic [DW-1:0] data_out,
   output logic [DW-1:0] dram_in,
   output logic [15:0]   addr_out,
   output logic [AW-1:0] addr_ins,
   output logic [5:0]    state
);

   typedef enum logic [5:0] {
      S_IDLE   = 6'h00,
      S_FETCH  = 6'h01,
      S_FWAIT  = 6'h02,
      S_DECODE = 6'h03,
      S_MEMRD  = 6'h04,
      S_EXEC   = 6'h05,
      S_HALT   = 6'h3F
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_MUL   = 4'h5;
   localparam logic [3:0] OP_JMP   = 4'h6;
   localparam logic [3:0] OP_JZ    = 4'h7;
   localparam logic [3:0] OP_LDI   = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;

   logic [DW-1:0] r_iram [0:(1<<AW)-1];
   logic [DW-1:0] r_dram [0:(1<<AW)-1];

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_acc;
   logic          r_z;
   logic [DW-1:0] r_ir;
   logic [DW-1:0] r_iramQ;
   logic [DW-1:0] r_dramQ;
   logic [DW-1:0] r_dataOut;

   logic          w_ext;
   logic [3:0]    w_op;
   logic [AW-1:0] w_operand;
   logic [AW-1:0] w_iAddr;
   logic [AW-1:0] w_dAddr;
   logic          w_iWe;
   logic          w_dWe;
   logic          w_iRd;
   logic [DW-1:0] w_dWrData;
   logic [DW-1:0] w_aluResult;
   logic          w_unusedBits;

   // The host owns both RAM ports only while the core is parked.
   assign w_ext     = (r_state == S_IDLE) || (r_state == S_HALT);
   assign w_op      = r_ir[15:12];
   assign w_operand = r_ir[AW-1:0];
   assign w_iAddr   = w_ext ? addr_ext[AW-1:0] : r_pc;
   assign w_dAddr   = w_ext ? addr_ext[AW-1:0] : w_operand;
   assign w_iWe     = w_ext && mem_write_ins;
   assign w_dWe     = (w_ext && mem_write_data_ext) || ((r_state == S_DECODE) && (w_op == OP_STORE));
   assign w_iRd     = (w_ext && read_en_ext[0]) || (r_state == S_FETCH);
   assign w_dWrData = (w_ext && mem_write_data_ext) ? data_in_ext : r_acc;
   assign w_unusedBits = ^{addr_ext[15:AW], r_ir[11:AW]};

   always_ff @(posedge clk) begin
      if (w_iWe) r_iram[w_iAddr] <= iram_in_ext;
      if (w_dWe) r_dram[w_dAddr] <= w_dWrData;
   end

   // Registered read ports; non-blocking reads give old data on a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iramQ   <= '0;
         r_dramQ   <= '0;
         r_dataOut <= '0;
      end else begin
         if (w_iRd) r_iramQ <= r_iram[w_iAddr];
         r_dramQ <= r_dram[w_dAddr];
         if (w_ext && read_en_ext[1]) r_dataOut <= r_dram[w_dAddr];
         else if (r_state == S_MEMRD) r_dataOut <= r_dramQ;
      end
   end

   always_comb begin
      w_aluResult = r_dataOut;
      case (w_op)
         OP_ADD:  w_aluResult = r_acc + r_dataOut;
         OP_SUB:  w_aluResult = r_acc - r_dataOut;
         OP_MUL:  w_aluResult = r_acc * r_dataOut;
         default: w_aluResult = r_dataOut;
      endcase
   end

   // Control FSM: FETCH/FWAIT/DECODE for every instruction, MEMRD/EXEC for memory operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= AW'(PC0);
         r_acc   <= '0;
         r_z     <= 1'b1;
         r_ir    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_state <= S_FETCH;
                  r_pc    <= AW'(PC0);
                  r_acc   <= '0;
                  r_z     <= 1'b1;
               end
            end
            S_FETCH: r_state <= S_FWAIT;
            S_FWAIT: begin
               r_ir    <= r_iramQ;
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_pc    <= r_pc + 1'b1;
               r_state <= S_FETCH;
               case (w_op)
                  OP_LOAD, OP_ADD, OP_SUB, OP_MUL: r_state <= S_MEMRD;
                  OP_JMP: r_pc <= w_operand;
                  OP_JZ:  if (r_z) r_pc <= w_operand;
                  OP_LDI: begin
                     r_acc <= {{(DW-AW){1'b0}}, w_operand};
                     r_z   <= (w_operand == '0);
                  end
                  OP_HALT: r_state <= S_HALT;
                  default: ;
               endcase
            end
            S_MEMRD: r_state <= S_EXEC;
            S_EXEC: begin
               r_acc   <= w_aluResult;
               r_z     <= (w_aluResult == '0);
               r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign iram_in  = r_iramQ;
   assign data_out = r_dataOut;
   assign dram_in  = w_dWrData;
   assign addr_out = {{(16-AW){1'b0}}, w_dAddr};
   assign addr_ins = w_iAddr;
   assign state    = r_state;

endmodule

// File: tb/tb_proc_top_layer.sv
// Scoreboard bench for proc_top_layer: host load/readback plus directed and random programs
// checked against a behavioural instruction-level model.
module tb_proc_top_layer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mem_write_ins = 1'b0;
   logic        mem_write_data_ext = 1'b0;
   logic [1:0]  read_en_ext = 2'b00;
   logic [15:0] addr_ext = 16'h0;
   logic [15:0] iram_in_ext = 16'h0;
   logic [15:0] data_in_ext = 16'h0;
   logic [15:0] iram_in;
   logic [15:0] data_out;
   logic [15:0] dram_in;
   logic [15:0] addr_out;
   logic [8:0]  addr_ins;
   logic [5:0]  state;

   proc_top_layer dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_write_ins(mem_write_ins), .mem_write_data_ext(mem_write_data_ext),
      .read_en_ext(read_en_ext), .addr_ext(addr_ext),
      .iram_in_ext(iram_in_ext), .data_in_ext(data_in_ext),
      .iram_in(iram_in), .data_out(data_out), .dram_in(dram_in),
      .addr_out(addr_out), .addr_ins(addr_ins), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          isDram;
      logic [15:0] expVal;
      int          addr;
   } expect_t;

   expect_t     scoreQ[$];
   logic [15:0] iramM [512];
   logic [15:0] dramM [512];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
      checks++;
      if (act !== expVal) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, expVal);
      end
   endtask

   // Instruction-level reference: runs the model program and returns the cycle count, or -1.
   function automatic int modelRun();
      int          pc;
      int          cyc;
      logic [15:0] acc;
      logic [15:0] ins;
      logic [15:0] m;
      pc  = 1;
      cyc = 0;
      acc = 16'h0;
      for (int step = 0; step < 5000; step++) begin
         ins = iramM[pc];
         pc  = (pc + 1) % 512;
         case (ins[15:12])
            4'h1, 4'h3, 4'h4, 4'h5: begin
               m   = dramM[ins[8:0]];
               cyc = cyc + 5;
               case (ins[15:12])
                  4'h1:    acc = m;
                  4'h3:    acc = 16'((longint'(acc) + longint'(m)) % 65536);
                  4'h4:    acc = 16'((longint'(acc) - longint'(m) + 65536) % 65536);
                  default: acc = 16'((longint'(acc) * longint'(m)) % 65536);
               endcase
            end
            4'h2: begin dramM[ins[8:0]] = acc; cyc = cyc + 3; end
            4'h6: begin pc = int'(ins[8:0]); cyc = cyc + 3; end
            4'h7: begin if (acc == 16'h0) pc = int'(ins[8:0]); cyc = cyc + 3; end
            4'h8: begin acc = {7'h0, ins[8:0]}; cyc = cyc + 3; end
            4'hF: return cyc + 3;
            default: cyc = cyc + 3;
         endcase
      end
      return -1;
   endfunction

   // Drives one host cycle; expected read data is queued before the model sees the write.
   task automatic applyStimulus(input bit wrI, input bit wrD, input logic [1:0] rd,
                                input logic [15:0] addr, input logic [15:0] iData, input logic [15:0] dData);
      expect_t e;
      @(negedge clk);
      mem_write_ins      = wrI;
      mem_write_data_ext = wrD;
      read_en_ext        = rd;
      addr_ext           = addr;
      iram_in_ext        = iData;
      data_in_ext        = dData;
      if (rd[0]) begin
         e.isDram = 1'b0; e.addr = int'(addr[8:0]); e.expVal = iramM[addr[8:0]];
         scoreQ.push_back(e);
      end
      if (rd[1]) begin
         e.isDram = 1'b1; e.addr = int'(addr[8:0]); e.expVal = dramM[addr[8:0]];
         scoreQ.push_back(e);
      end
      if (wrI) iramM[addr[8:0]] = iData;
      if (wrD) dramM[addr[8:0]] = dData;
      #1;
      checkOutput("addr_ins_idle", 32'(addr_ins), 32'(addr[8:0]));
      checkOutput("addr_out_idle", 32'(addr_out), 32'(addr[8:0]));
      if (wrD) checkOutput("dram_in_mirror", 32'(dram_in), 32'(dData));
   endtask

   task automatic busIdle();
      @(negedge clk);
      mem_write_ins      = 1'b0;
      mem_write_data_ext = 1'b0;
      read_en_ext        = 2'b00;
      addr_ext           = 16'h0;
      iram_in_ext        = 16'h0;
      data_in_ext        = 16'h0;
   endtask

   task automatic readConst(input logic [8:0] a, input logic [15:0] expVal);
      expect_t e;
      @(negedge clk);
      mem_write_ins      = 1'b0;
      mem_write_data_ext = 1'b0;
      read_en_ext        = 2'b10;
      addr_ext           = {7'h0, a};
      e.isDram = 1'b1; e.addr = int'(a); e.expVal = expVal;
      scoreQ.push_back(e);
   endtask

   task automatic loadBinaryProgram(input logic [15:0] op2, input logic [15:0] m1, input logic [15:0] m2);
      applyStimulus(1'b0, 1'b1, 2'b00, 16'd1, 16'h0, m1);
      applyStimulus(1'b0, 1'b1, 2'b00, 16'd2, 16'h0, m2);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd1, 16'h1001, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd2, op2, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd3, 16'h2003, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd4, 16'hF000, 16'h0);
      busIdle();
   endtask

   // Pulses start, optionally tries host writes mid-run, and checks the cycle count to HALT.
   task automatic runProgram(input string tag, input bit intrude);
      int expCyc;
      int cyc;
      bit done;
      expCyc = modelRun();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 3000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (intrude && cyc == 1) begin
            mem_write_data_ext = 1'b1; mem_write_ins = 1'b1;
            addr_ext = 16'd3; data_in_ext = 16'hFFFF; iram_in_ext = 16'hF000;
         end
         if (intrude && cyc == 6) begin
            mem_write_data_ext = 1'b0; mem_write_ins = 1'b0;
            addr_ext = 16'h0; data_in_ext = 16'h0; iram_in_ext = 16'h0;
         end
         if (state == 6'h3F) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL %s_timeout actual=no_halt required=halt", tag);
      end else begin
         checkOutput({tag, "_cycles"}, 32'(cyc), 32'(expCyc));
      end
   endtask

   // Monitor: a read issued on an edge presents its data just after that edge.
   initial begin : monitor
      logic [1:0] rdSeen;
      expect_t    e;
      forever begin
         @(posedge clk);
         rdSeen = read_en_ext;
         #1;
         for (int b = 0; b < 2; b++) begin
            if (rdSeen[b]) begin
               if (scoreQ.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_read actual=read required=none");
               end else begin
                  e = scoreQ.pop_front();
                  if (b == 1)
                     checkOutput($sformatf("dram_rb[%0d]", e.addr), 32'(data_out), 32'(e.expVal));
                  else
                     checkOutput($sformatf("iram_rb[%0d]", e.addr), 32'(iram_in), 32'(e.expVal));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int          len;
      int          k;
      int          mrCnt;
      logic [3:0]  op;
      logic [8:0]  a;
      logic [15:0] v;

      #3 rst = 1'b1;
      #1;
      checkOutput("rst_state", 32'(state), 32'h00);
      checkOutput("rst_iram_in", 32'(iram_in), 32'h0);
      checkOutput("rst_data_out", 32'(data_out), 32'h0);
      checkOutput("rst_dram_in", 32'(dram_in), 32'h0);
      checkOutput("rst_addr_out", 32'(addr_out), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed ADD program, then readback of its image.
      loadBinaryProgram(16'h3002, 16'd5, 16'd7);
      applyStimulus(1'b0, 1'b0, 2'b01, 16'd2, 16'h0, 16'h0);
      applyStimulus(1'b0, 1'b0, 2'b10, 16'hFE01, 16'h0, 16'h0);
      busIdle();
      runProgram("add", 1'b0);
      readConst(9'd3, 16'd12);
      busIdle();
      repeat (2) @(negedge clk);
      checkOutput("halt_hold", 32'(state), 32'h3F);

      // Host readback, read-first on collision, dual write, and output hold.
      applyStimulus(1'b0, 1'b1, 2'b00, 16'd9, 16'h0, 16'hBEEF);
      applyStimulus(1'b0, 1'b0, 2'b10, 16'd9, 16'h0, 16'h0);
      applyStimulus(1'b0, 1'b1, 2'b10, 16'd9, 16'h0, 16'h1234);
      applyStimulus(1'b0, 1'b0, 2'b10, 16'd9, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b1, 2'b00, 16'd20, 16'hA5A5, 16'h5A5A);
      applyStimulus(1'b0, 1'b0, 2'b01, 16'd20, 16'h0, 16'h0);
      applyStimulus(1'b0, 1'b0, 2'b10, 16'd20, 16'h0, 16'h0);
      busIdle();
      repeat (3) @(negedge clk);
      checkOutput("data_out_hold", 32'(data_out), 32'h5A5A);

      loadBinaryProgram(16'h5002, 16'd5, 16'd7);
      runProgram("mul", 1'b0);
      readConst(9'd3, 16'd35);
      busIdle();
      loadBinaryProgram(16'h5002, 16'd300, 16'd300);
      runProgram("mul_wrap", 1'b0);
      readConst(9'd3, 16'd24464);
      busIdle();
      loadBinaryProgram(16'h4002, 16'd5, 16'd7);
      runProgram("sub", 1'b0);
      readConst(9'd3, 16'hFFFE);
      busIdle();

      // Host writes while running must be ignored.
      loadBinaryProgram(16'h3002, 16'd5, 16'd7);
      runProgram("intrude", 1'b1);
      readConst(9'd3, 16'd12);
      busIdle();
      applyStimulus(1'b0, 1'b0, 2'b01, 16'd3, 16'h0, 16'h0);
      busIdle();

      // Reset in MEMRD aborts; a restart reproduces the result.
      applyStimulus(1'b0, 1'b1, 2'b00, 16'd3, 16'h0, 16'h0);
      busIdle();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      mrCnt = 0;
      while (state != 6'h04 && mrCnt < 50) begin
         @(posedge clk); mrCnt++; #1;
      end
      checkOutput("reach_memrd", 32'(state), 32'h04);
      rst = 1'b1;
      #1;
      checkOutput("midrun_rst_state", 32'(state), 32'h00);
      checkOutput("midrun_rst_acc", 32'(dram_in), 32'h0);
      checkOutput("midrun_rst_data_out", 32'(data_out), 32'h0);
      checkOutput("midrun_rst_addr_ins", 32'(addr_ins), 32'h0);
      @(negedge clk); rst = 1'b0;
      runProgram("restart", 1'b0);
      readConst(9'd3, 16'd12);
      busIdle();

      // LDI 0 then JZ taken skips LDI 1 and the STORE.
      applyStimulus(1'b0, 1'b1, 2'b00, 16'd3, 16'h0, 16'h1111);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd1, 16'h8000, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd2, 16'h7005, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd3, 16'h8001, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd4, 16'h2003, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd5, 16'hF000, 16'h0);
      busIdle();
      runProgram("jz_taken", 1'b0);
      readConst(9'd3, 16'h1111);
      busIdle();

      // PC wraps 511 -> 0.
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd511, 16'h8055, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd0, 16'h6002, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd1, 16'h61FF, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd2, 16'h201F, 16'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 16'd3, 16'hF000, 16'h0);
      busIdle();
      runProgram("pc_wrap", 1'b0);
      readConst(9'd31, 16'h0055);
      busIdle();

      // Random forward-branching programs over DRAM[0..31], result stored to DRAM[31].
      for (int prog = 0; prog < 4; prog++) begin
         for (int d = 0; d < 32; d++) begin
            v = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            applyStimulus(1'b0, 1'b1, 2'b00, {7'($urandom), 9'(d)}, 16'h0, v);
         end
         len = $urandom_range(6, 14);
         for (int pc = 1; pc <= len; pc++) begin
            k = $urandom_range(0, 9);
            case (k)
               0: op = 4'h1;  1: op = 4'h2;  2: op = 4'h3;  3: op = 4'h4;
               4: op = 4'h5;  5: op = 4'h8;  6: op = 4'h6;  7: op = 4'h7;
               8: op = 4'h0;
               default: op = 4'($urandom_range(9, 14));
            endcase
            a = 9'($urandom_range(0, 30));
            if (op == 4'h6 || op == 4'h7) a = 9'($urandom_range(pc + 1, len + 1));
            if (op == 4'h8) a = 9'($urandom);
            applyStimulus(1'b1, 1'b0, 2'b00, {7'($urandom), 9'(pc)}, {op, 3'($urandom), a}, 16'h0);
         end
         applyStimulus(1'b1, 1'b0, 2'b00, 16'(len + 1), 16'h201F, 16'h0);
         applyStimulus(1'b1, 1'b0, 2'b00, 16'(len + 2), {4'hF, 12'($urandom)}, 16'h0);
         busIdle();
         runProgram($sformatf("rand%0d", prog), 1'b0);
         for (int d = 0; d < 32; d++)
            applyStimulus(1'b0, 1'b0, 2'b10, {7'($urandom), 9'(d)}, 16'h0, 16'h0);
         applyStimulus(1'b0, 1'b0, 2'b01, 16'(len), 16'h0, 16'h0);
         busIdle();
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
